// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline: byte-serial little-endian loads/stores over an 8-bit RAM port.
// Optional MEM_LOAD_FWD_EN adds a combinational forwarding path (mem_fwd_*) toward ID.
`ifndef LB
`define LB  6'd1
`endif
`ifndef LH
`define LH  6'd2
`endif
`ifndef LW
`define LW  6'd3
`endif
`ifndef LBU
`define LBU 6'd4
`endif
`ifndef LHU
`define LHU 6'd5
`endif
`ifndef SB
`define SB  6'd6
`endif
`ifndef SH
`define SH  6'd7
`endif
`ifndef SW
`define SW  6'd8
`endif

module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        in_status,
    input  logic [5:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [4:0]        in_rd,
    input  logic [7:0]        mem_din,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    output logic              mem_wr,
    output logic              stall_req,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [1:0]        dbg_state
`ifdef MEM_LOAD_FWD_EN
   ,output logic              mem_fwd_valid,
    output logic [4:0]        mem_fwd_rd,
    output logic [DATA_W-1:0] mem_fwd_data
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } state_t;

    state_t            state_q;
    logic [5:0]        op_q;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] data_q;
    logic [4:0]        rd_q;
    logic [2:0]        cnt_q;
    logic [DATA_W-1:0] asm_q;
    logic [ADDR_W-1:0] mem_a_q;
    logic [7:0]        mem_dout_q;
    logic              mem_wr_q;
    logic              wb_we_q;
    logic [4:0]        wb_rd_q;
    logic [DATA_W-1:0] wb_data_q;

    logic [DATA_W-1:0] asm_d;
    logic [DATA_W-1:0] ld_result;
    logic [2:0]        size_q;
    logic              last_byte;
    logic [ADDR_W-1:0] ld_addr_next;
    logic [ADDR_W-1:0] st_addr;
    logic [7:0]        st_byte;
    logic              stall_d;

    function automatic logic [2:0] acc_size(input logic [5:0] op);
        case (op)
            `LB, `LBU, `SB: acc_size = 3'd1;
            `LH, `LHU, `SH: acc_size = 3'd2;
            default:        acc_size = 3'd4;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] extend(input logic [5:0] op, input logic [DATA_W-1:0] v);
        case (op)
            `LB:     extend = {{(DATA_W-8){v[7]}}, v[7:0]};
            `LBU:    extend = {{(DATA_W-8){1'b0}}, v[7:0]};
            `LH:     extend = {{(DATA_W-16){v[15]}}, v[15:0]};
            `LHU:    extend = {{(DATA_W-16){1'b0}}, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    assign size_q       = acc_size(op_q);
    assign last_byte    = (cnt_q + 3'd1) == size_q;
    assign ld_addr_next = base_q + ADDR_W'(cnt_q) + ADDR_W'(1);
    assign st_addr      = base_q + ADDR_W'(cnt_q);
    assign st_byte      = data_q[{cnt_q[1:0], 3'b000} +: 8];

    // The byte arriving this cycle merged into its lane; the final load value is taken from here.
    always_comb begin
        asm_d = asm_q;
        asm_d[{cnt_q[1:0], 3'b000} +: 8] = mem_din;
    end

    assign ld_result = extend(op_q, asm_d);

    always_comb begin
        stall_d = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE:    stall_d = (in_status == 3'b011) ||
                                   ((in_status == 3'b010) && (in_op != `SB));
                LOAD:    stall_d = 1'b1;
                STORE:   stall_d = cnt_q < size_q;
                default: stall_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= 6'd0;
            base_q     <= '0;
            data_q     <= '0;
            rd_q       <= 5'd0;
            cnt_q      <= 3'd0;
            asm_q      <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    mem_wr_q <= 1'b0;
                    wb_we_q  <= 1'b0;
                    case (in_status)
                        3'b001, 3'b101: begin
                            wb_we_q   <= in_rd != 5'd0;
                            wb_rd_q   <= in_rd;
                            wb_data_q <= in_data;
                        end
                        3'b011: begin
                            op_q    <= in_op;
                            base_q  <= in_addr;
                            rd_q    <= in_rd;
                            mem_a_q <= in_addr;
                            cnt_q   <= 3'd0;
                            asm_q   <= '0;
                            state_q <= LOAD;
                        end
                        3'b010: begin
                            op_q       <= in_op;
                            base_q     <= in_addr;
                            data_q     <= in_data;
                            mem_a_q    <= in_addr;
                            mem_dout_q <= in_data[7:0];
                            mem_wr_q   <= 1'b1;
                            cnt_q      <= 3'd1;
                            state_q    <= STORE;
                        end
                        default: ;
                    endcase
                end
                LOAD: begin
                    mem_wr_q <= 1'b0;
                    asm_q    <= asm_d;
                    cnt_q    <= cnt_q + 3'd1;
                    if (last_byte) begin
                        wb_we_q   <= rd_q != 5'd0;
                        wb_rd_q   <= rd_q;
                        wb_data_q <= ld_result;
                        state_q   <= IDLE;
                    end else begin
                        mem_a_q <= ld_addr_next;
                    end
                end
                STORE: begin
                    wb_we_q <= 1'b0;
                    if (cnt_q < size_q) begin
                        mem_a_q    <= st_addr;
                        mem_dout_q <= st_byte;
                        mem_wr_q   <= 1'b1;
                        cnt_q      <= cnt_q + 3'd1;
                    end else begin
                        mem_wr_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = mem_wr_q;
    assign stall_req = stall_d;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign dbg_state = state_q;

`ifdef MEM_LOAD_FWD_EN
    always_comb begin
        mem_fwd_valid = 1'b0;
        mem_fwd_rd    = 5'd0;
        mem_fwd_data  = '0;
        if (!rst) begin
            if ((state_q == IDLE) && ((in_status == 3'b001) || (in_status == 3'b101))) begin
                mem_fwd_valid = in_rd != 5'd0;
                mem_fwd_rd    = in_rd;
                mem_fwd_data  = in_data;
            end else if ((state_q == LOAD) && last_byte) begin
                mem_fwd_valid = rd_q != 5'd0;
                mem_fwd_rd    = rd_q;
                mem_fwd_data  = ld_result;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: byte RAM model, write-back and RAM-write scoreboards.
`timescale 1ns/1ps
`ifndef LB
`define LB  6'd1
`endif
`ifndef LH
`define LH  6'd2
`endif
`ifndef LW
`define LW  6'd3
`endif
`ifndef LBU
`define LBU 6'd4
`endif
`ifndef LHU
`define LHU 6'd5
`endif
`ifndef SB
`define SB  6'd6
`endif
`ifndef SH
`define SH  6'd7
`endif
`ifndef SW
`define SW  6'd8
`endif

module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  in_status;
    logic [5:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [4:0]  in_rd;
    logic [7:0]  mem_din;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic        stall_req;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  dbg_state;
`ifdef MEM_LOAD_FWD_EN
    logic        mem_fwd_valid;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_data;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [36:0] wb_exp_q[$];
    logic [39:0] wr_exp_q[$];
    logic [36:0] wb_e;
    logic [39:0] wr_e;

    logic [7:0]  ram [0:4095];
    logic        poke_en = 1'b0;
    logic [11:0] poke_a = 12'd0;
    logic [7:0]  poke_d = 8'd0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_status (in_status),
        .in_op     (in_op),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_rd     (in_rd),
        .mem_din   (mem_din),
        .mem_a     (mem_a),
        .mem_dout  (mem_dout),
        .mem_wr    (mem_wr),
        .stall_req (stall_req),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .dbg_state (dbg_state)
`ifdef MEM_LOAD_FWD_EN
       ,.mem_fwd_valid (mem_fwd_valid),
        .mem_fwd_rd    (mem_fwd_rd),
        .mem_fwd_data  (mem_fwd_data)
`endif
    );

    // RAM model: byte read is valid the cycle after mem_a is registered.
    assign mem_din = ram[mem_a[11:0]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'(i * 37 + 11);
        end else begin
            if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
            if (poke_en) ram[poke_a] <= poke_d;
        end
    end

    // Scoreboard: every write-back pulse and RAM write must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && wb_we === 1'b1) begin
            tests_run++;
            if (wb_exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h, expected no write-back", wb_rd, wb_data);
            end else begin
                wb_e = wb_exp_q.pop_front();
                if ({wb_rd, wb_data} !== wb_e) begin
                    tests_failed++;
                    $display("FAIL wb_record: got rd=%0d data=%h, expected rd=%0d data=%h",
                             wb_rd, wb_data, wb_e[36:32], wb_e[31:0]);
                end
            end
        end
        if (!rst && mem_wr === 1'b1) begin
            tests_run++;
            if (wr_exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL wr_unexpected: got %h@%h, expected no RAM write", mem_dout, mem_a);
            end else begin
                wr_e = wr_exp_q.pop_front();
                if ({mem_a, mem_dout} !== wr_e) begin
                    tests_failed++;
                    $display("FAIL wr_byte: got %h@%h, expected %h@%h",
                             mem_dout, mem_a, wr_e[7:0], wr_e[39:8]);
                end
            end
        end
    end

    function automatic int size_of(input logic [5:0] op);
        if (op == `LB || op == `LBU || op == `SB) return 1;
        if (op == `LH || op == `LHU || op == `SH) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] addr);
        logic [31:0] v;
        logic [31:0] a;
        v = 32'd0;
        for (int k = 0; k < size_of(op); k++) begin
            a = addr + 32'(k);
            v[8*k +: 8] = ram[a[11:0]];
        end
        if (op == `LB)  v = {{24{v[7]}}, v[7:0]};
        if (op == `LH)  v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic set_in(input logic [2:0] st, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] rd);
        in_status = st;
        in_op     = op;
        in_addr   = addr;
        in_data   = data;
        in_rd     = rd;
    endtask

    task automatic bubble();
        set_in(3'b000, 6'd0, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        poke_en = 1'b1;
        poke_a  = a;
        poke_d  = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic run_alu(input logic [2:0] st, input logic [4:0] rd, input logic [31:0] data);
        logic exp_we;
        exp_we = ((st == 3'b001) || (st == 3'b101)) && (rd != 5'd0);
        if (exp_we) wb_exp_q.push_back({rd, data});
        set_in(st, 6'd0, 32'd0, data, rd);
        @(negedge clk);
        tests_run++;
        if (stall_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL alu_stall: got %b, expected 0 (status %b)", stall_req, st);
        end
        @(posedge clk); #1;
        bubble();
        @(negedge clk);
        tests_run++;
        if (wb_we !== exp_we) begin
            tests_failed++;
            $display("FAIL alu_wb_we: got %b, expected %b (status %b rd %0d)", wb_we, exp_we, st, rd);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_load(input logic [5:0] op, input logic [31:0] addr, input logic [4:0] rd,
                            input logic [31:0] exp_data, input bit check_addr);
        int n;
        n = size_of(op);
        if (rd != 5'd0) wb_exp_q.push_back({rd, exp_data});
        set_in(3'b011, op, addr, 32'd0, rd);
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            tests_run++;
            if (stall_req !== 1'b1) begin
                tests_failed++;
                $display("FAIL load_stall: got %b, expected 1 in load cycle %0d", stall_req, i);
            end
            if (check_addr && i > 0) begin
                tests_run++;
                if (mem_a !== addr + 32'(i - 1)) begin
                    tests_failed++;
                    $display("FAIL load_addr: got %h, expected %h in load cycle %0d",
                             mem_a, addr + 32'(i - 1), i);
                end
            end
            if (i == n) begin
                tests_run++;
                if (wb_we !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL load_early_wb: got wb_we=%b, expected 0 before acceptance+%0d", wb_we, n + 1);
                end
            end
            @(posedge clk); #1;
        end
        bubble();
        @(negedge clk);
        tests_run++;
        if (stall_req !== 1'b0 || wb_we !== (rd != 5'd0)) begin
            tests_failed++;
            $display("FAIL load_done: got stall=%b wb_we=%b, expected stall=0 wb_we=%b",
                     stall_req, wb_we, rd != 5'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_store(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data);
        int n;
        n = size_of(op);
        for (int k = 0; k < n; k++) wr_exp_q.push_back({addr + 32'(k), data[8*k +: 8]});
        set_in(3'b010, op, addr, data, 5'd9);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tests_run++;
            if (stall_req !== (op != `SB)) begin
                tests_failed++;
                $display("FAIL store_stall: got %b, expected %b in store cycle %0d", stall_req, op != `SB, i);
            end
            @(posedge clk); #1;
        end
        bubble();
        @(negedge clk);
        tests_run++;
        if (stall_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_stall_end: got %b, expected 0 in store cycle %0d", stall_req, n);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (mem_wr !== 1'b0 || wb_we !== 1'b0 || wr_exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL store_done: got mem_wr=%b wb_we=%b pending=%0d, expected 0 0 0",
                     mem_wr, wb_we, wr_exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(3'b011, `LW, 32'h300, 32'd0, 5'd2);
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if ({mem_a, mem_dout, mem_wr, wb_we, wb_rd, wb_data, stall_req, dbg_state} !== 82'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got a=%h dout=%h wr=%b we=%b rd=%0d data=%h stall=%b st=%0d, expected all 0",
                     mem_a, mem_dout, mem_wr, wb_we, wb_rd, wb_data, stall_req, dbg_state);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (stall_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_accept_stall: got %b, expected 1", stall_req);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (stall_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_stall: got %b, expected 0 while rst=1", stall_req);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        bubble();
        @(negedge clk);
        tests_run++;
        if ({mem_a, mem_dout, mem_wr, wb_we, wb_rd, wb_data, stall_req, dbg_state} !== 82'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_load: got a=%h dout=%h wr=%b we=%b rd=%0d data=%h stall=%b st=%0d, expected all 0",
                     mem_a, mem_dout, mem_wr, wb_we, wb_rd, wb_data, stall_req, dbg_state);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            tests_run++;
            if (wb_we !== 1'b0 || mem_wr !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_no_wb: got wb_we=%b mem_wr=%b, expected 0 0 (cycle %0d)", wb_we, mem_wr, i);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        run_alu(3'b001, 5'd5, 32'h12345678);
        run_alu(3'b001, 5'd0, 32'hDEADBEEF);
        run_alu(3'b101, 5'd31, $urandom);
        run_alu(3'b000, 5'd7, 32'h0000_1111);
        run_alu(3'b100, 5'd8, 32'h0000_2222);
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rd;
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            rd = 5'($urandom_range(1, 31));
            d  = $urandom;
            wb_exp_q.push_back({rd, d});
            set_in((i % 2 == 0) ? 3'b001 : 3'b101, 6'd0, 32'd0, d, rd);
            @(posedge clk); #1;
        end
        bubble();
        repeat (2) begin @(posedge clk); #1; end
        tests_run++;
        if (wb_exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_drain: got %0d pending write-backs, expected 0", wb_exp_q.size());
        end
    endtask

    task automatic test_store();
        run_store(`SW, 32'h100, 32'hAABBCCDD);
        run_store(`SH, 32'h120, $urandom);
        run_store(`SB, 32'h130, 32'h0000_005A);
        run_load(`LW, 32'h100, 5'd10, 32'hAABBCCDD, 1'b1);
        run_load(`LBU, 32'h130, 5'd11, 32'h0000_005A, 1'b0);
    endtask

    task automatic test_load_ext();
        poke(12'h200, 8'h80);
        poke(12'h210, 8'h34);
        poke(12'h211, 8'h96);
        run_load(`LB,  32'h200, 5'd3, 32'hFFFFFF80, 1'b1);
        run_load(`LBU, 32'h200, 5'd4, 32'h00000080, 1'b0);
        run_load(`LH,  32'h210, 5'd6, 32'hFFFF9634, 1'b1);
        run_load(`LHU, 32'h210, 5'd7, 32'h00009634, 1'b0);
        run_load(`LW,  32'h200, 5'd0, 32'h0, 1'b0);
    endtask

    task automatic test_lw_wrap();
        poke(12'hFFE, 8'h11);
        poke(12'hFFF, 8'h22);
        poke(12'h000, 8'h33);
        poke(12'h001, 8'h44);
        run_load(`LW, 32'hFFFFFFFE, 5'd8, 32'h44332211, 1'b1);
    endtask

    task automatic test_random_loads();
        logic [5:0]  ops [0:4];
        logic [5:0]  op;
        logic [31:0] addr;
        ops[0] = `LB; ops[1] = `LH; ops[2] = `LW; ops[3] = `LBU; ops[4] = `LHU;
        for (int i = 0; i < 8; i++) begin
            op   = ops[$urandom_range(0, 4)];
            addr = 32'h400 + 32'($urandom_range(0, 255));
            run_load(op, addr, 5'($urandom_range(1, 31)), model_load(op, addr), 1'b1);
        end
    endtask

    initial begin
        bubble();
        test_reset();
        test_alu();
        test_back_to_back();
        test_store();
        test_load_ext();
        test_lw_wrap();
        test_random_loads();
        repeat (3) begin @(posedge clk); #1; end
        tests_run++;
        if (wb_exp_q.size() != 0 || wr_exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL final_drain: got wb pending=%0d wr pending=%0d, expected 0 0",
                     wb_exp_q.size(), wr_exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 ns, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline. Sits between the EX/MEM latch and the MEM/WB latch.
- Consumes the execute-stage outputs: status, op, memory address, target data and rd address.
- Performs loads and stores over the byte-wide RAM port, one byte per cycle, little-endian.
- Stalls the upstream pipeline while a multi-byte access is in flight, then delivers the write-back record.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, register/data width; fixed at 32 for RV32I.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_status  in  3  000 bubble, 001 reg write, 010 mem write, 011 mem read, 100 branch, 101 jal/jalr.
- in_op  in  6  opcode from the shared defines header (`LB, `LH, `LW, `LBU, `LHU, `SB, `SH, `SW; others pass through).
- in_addr  in  32  effective memory address.
- in_data  in  32  store data, or ALU/link result for 001/101.
- in_rd  in  5  destination register.
- mem_din  in  8  RAM read byte; valid the cycle after the address is registered on mem_a.
- mem_a  out  32  RAM byte address, registered.
- mem_dout  out  8  RAM write byte, registered.
- mem_wr  out  1  RAM write strobe, registered; 1 = write.
- stall_req  out  1  combinational; holds PC, IF/ID, ID/EX and EX/MEM while high.
- wb_we  out  1  registered; write-back enable to MEM/WB.
- wb_rd  out  5  registered; write-back register.
- wb_data  out  32  registered; write-back value.

Behaviour:
- Reset: when rst=1 at a clock edge:
  - State goes to IDLE.
  - mem_a=0, mem_dout=0, mem_wr=0, wb_we=0, wb_rd=0, wb_data=0, byte counter=0, assembly register=0.
  - stall_req=0 while rst=1.
  - Reset mid-access abandons the access; no partial write-back is produced.
- Access size N: 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW.
- States: IDLE, LOAD, STORE.
- IDLE:
  - in_status 001 or 101: next cycle wb_we=(in_rd!=0), wb_rd=in_rd, wb_data=in_data. Latency 1, no stall.
  - in_status 000 or 100: next cycle wb_we=0.
  - in_status 011: latch op/addr/rd, register mem_a=in_addr, mem_wr=0, counter=0, go to LOAD, wb_we=0.
  - in_status 010: latch op/addr/data, register mem_a=in_addr, mem_dout=in_data[7:0], mem_wr=1, counter=1, go to STORE, wb_we=0.
  - stall_req is high in IDLE whenever in_status is 010/011, except for an SB in IDLE.
- LOAD:
  - Each cycle, mem_din is placed into byte lane (counter) of the assembly register, then counter increments.
  - While more bytes remain, mem_a=base+counter+1.
  - After byte N-1 is captured: wb_we=(rd!=0), wb_rd=rd, wb_data as below; state returns to IDLE.
  - wb_data for LB/LH: sign-extended from bit 7/15. LBU/LHU: zero-extended. LW: unmodified.
  - The write-back record is registered N+1 cycles after acceptance.
  - stall_req stays high through the cycle in which the last byte is captured.
- STORE:
  - Each cycle with counter<N: mem_a=base+counter, mem_dout=data byte (counter), mem_wr=1, counter increments.
  - When counter==N: mem_wr=0, return to IDLE, wb_we=0.
  - stall_req is high until the cycle in which the final byte is registered.
- Address arithmetic: 32-bit, wraps modulo 2^32 (0xFFFFFFFF+1 = 0x00000000).
- Misalignment is not checked; bytes are accessed sequentially from the given address.
- mem_wr is 0 in every cycle outside STORE byte issue.
- Inputs are sampled only in IDLE. Upstream holds its inputs stable while stall_req is high.
- rd==0 never produces wb_we=1.

Optional Feature:
- MEM_LOAD_FWD_EN defined:
  - Adds outputs mem_fwd_valid (1), mem_fwd_rd (5), mem_fwd_data (32), all combinational.
  - In the LOAD cycle that captures the last byte, they present the completed, extended value to ID one cycle early.
  - For 001/101 in IDLE they present in_data/in_rd.
  - mem_fwd_valid=0 for rd==0 and in all other cases.
- Not defined:
  - Ports absent; ID relies on the MEM/WB value only.

Test Plan:
- Reset: assert rst for 2 cycles during a LW in LOAD -> all outputs 0, state IDLE, no wb_we pulse afterwards.
- ALU pass-through: status 001, rd=5, data=0x12345678 -> next cycle wb_we=1, wb_rd=5, wb_data=0x12345678, stall_req=0.
- rd=0: status 001, rd=0 -> wb_we=0.
- SW:
  - Stimulus: addr 0x100, data 0xAABBCCDD.
  - Writes 0xDD@0x100, 0xCC@0x101, 0xBB@0x102, 0xAA@0x103 on consecutive cycles, mem_wr=1 each.
  - Then mem_wr=0, no wb_we.
- LB sign extension: RAM 0x200=0x80, LB rd=3 -> wb_data=0xFFFFFF80. LBU -> 0x00000080.
- LW wrap: addr 0xFFFFFFFE -> mem_a sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
- LW latency and stall: any LW -> stall_req high for exactly the load duration; wb valid at acceptance+5.
